// File: rtl/led_matrix_scan.sv
// Scan controller for a 16x16 LED dot-matrix panel: shifts each row's pixels
// from the glyph ROM into the column register, latches them, then lights the row.
module led_matrix_scan #(
    parameter int CLK_DIV          = 4,
    parameter int ROW_HOLD         = 1000,
    parameter int FRAMES_PER_GLYPH = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pixel,
    output logic [3:0]  row,
    output logic [3:0]  col,
    output logic [1:0]  select,
    output logic        sclk,
    output logic        sdata,
    output logic        latch,
    output logic [15:0] row_en,
    output logic        frame_done
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int HW = $clog2(ROW_HOLD + 1);
    localparam int FW = $clog2(FRAMES_PER_GLYPH + 1);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_LAST = HW'(ROW_HOLD - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_GLYPH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t         state_q, state_d;
    logic [3:0]     row_q, row_d;
    logic [3:0]     col_q, col_d;
    logic [1:0]     select_q, select_d;
    logic           sclk_q, sclk_d;
    logic           sdata_q, sdata_d;
    logic           latch_q, latch_d;
    logic [15:0]    row_en_q, row_en_d;
    logic           frame_done_q, frame_done_d;
    logic [PW-1:0]  p_q, p_d, p_next_s;
    logic [HW-1:0]  hold_q, hold_d;
    logic [FW-1:0]  frame_q, frame_d;

    // Next-state and next-output logic for the scan sequencer
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        select_d     = select_q;
        sclk_d       = 1'b0;
        sdata_d      = sdata_q;
        latch_d      = 1'b0;
        row_en_d     = 16'h0000;
        frame_done_d = 1'b0;
        p_d          = p_q;
        hold_d       = hold_q;
        frame_d      = frame_q;
        if (p_q == P_LAST) begin
            p_next_s = {PW{1'b0}};
        end else begin
            p_next_s = p_q + PW'(1);
        end

        // Disable aborts the scan but keeps glyph selection and frame count.
        if (!enable) begin
            state_d = IDLE;
            row_d   = 4'd0;
            col_d   = 4'd0;
            p_d     = {PW{1'b0}};
            hold_d  = {HW{1'b0}};
            sdata_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHIFT;
                end
                SHIFT: begin
                    p_d = p_next_s;
                    if (p_q == {PW{1'b0}}) begin
                        sdata_d = pixel;
                    end else begin
                        sdata_d = sdata_q;
                    end
                    if (p_q == P_LAST) begin
                        col_d = col_q + 4'd1;
                        if (col_q == 4'd15) begin
                            state_d = LATCH;
                            latch_d = 1'b1;
                        end else begin
                            state_d = SHIFT;
                        end
                    end else begin
                        sclk_d = (p_next_s >= P_HALF);
                    end
                end
                LATCH: begin
                    state_d  = DISPLAY;
                    hold_d   = {HW{1'b0}};
                    row_en_d = 16'd1 << row_q;
                end
                DISPLAY: begin
                    if (hold_q == H_LAST) begin
                        hold_d  = {HW{1'b0}};
                        row_d   = row_q + 4'd1;
                        state_d = SHIFT;
                        if (row_q == 4'd15) begin
                            frame_done_d = 1'b1;
                            if (frame_q == F_LAST) begin
                                frame_d  = {FW{1'b0}};
                                select_d = (select_q == 2'd1) ? 2'd2 : 2'd1;
                            end else begin
                                frame_d = frame_q + FW'(1);
                            end
                        end else begin
                            frame_done_d = 1'b0;
                        end
                    end else begin
                        hold_d   = hold_q + HW'(1);
                        row_en_d = 16'd1 << row_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= 4'd0;
            col_q        <= 4'd0;
            select_q     <= 2'd1;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            latch_q      <= 1'b0;
            row_en_q     <= 16'h0000;
            frame_done_q <= 1'b0;
            p_q          <= {PW{1'b0}};
            hold_q       <= {HW{1'b0}};
            frame_q      <= {FW{1'b0}};
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            select_q     <= select_d;
            sclk_q       <= sclk_d;
            sdata_q      <= sdata_d;
            latch_q      <= latch_d;
            row_en_q     <= row_en_d;
            frame_done_q <= frame_done_d;
            p_q          <= p_d;
            hold_q       <= hold_d;
            frame_q      <= frame_d;
        end
    end

    assign row        = row_q;
    assign col        = col_q;
    assign select     = select_q;
    assign sclk       = sclk_q;
    assign sdata      = sdata_q;
    assign latch      = latch_q;
    assign row_en     = row_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Self-checking bench for led_matrix_scan: glyph ROM model, sdata scoreboard,
// frame table for glyph alternation, plus abort and asynchronous-reset sequences.
module tb_led_matrix_scan;
    localparam int CLK_DIV      = 4;
    localparam int ROW_HOLD     = 4;
    localparam int FPG          = 2;
    localparam int ROW_PERIOD   = 16 * CLK_DIV + 1 + ROW_HOLD;
    localparam int FRAME_PERIOD = 16 * ROW_PERIOD;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        pixel;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [1:0]  select;
    logic        sclk;
    logic        sdata;
    logic        latch;
    logic [15:0] row_en;
    logic        frame_done;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   first_row = 1'b1;
    bit   have_latch = 1'b0;
    int   last_latch = 0;
    int   last_fd = -1;
    logic exp_q[$];

    typedef struct {
        logic [1:0] sel;
        logic [1:0] sel_after;
        bit         abort_before;
    } frame_vec_t;
    frame_vec_t tbl[6];

    led_matrix_scan #(
        .CLK_DIV(CLK_DIV), .ROW_HOLD(ROW_HOLD), .FRAMES_PER_GLYPH(FPG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pixel(pixel),
        .row(row), .col(col), .select(select), .sclk(sclk), .sdata(sdata),
        .latch(latch), .row_en(row_en), .frame_done(frame_done)
    );

    // Glyph ROM: bit 15 of each row word is column 0.
    function automatic logic rom_bit(input logic [1:0] s, input logic [3:0] r, input logic [3:0] c);
        logic [15:0] w;
        if (s == 2'd1)      w = 16'h0FF0 ^ {4{r ^ 4'd2}};
        else if (s == 2'd2) w = 16'hE007 ^ {4{r ^ 4'd1}};
        else                w = 16'h0000;
        return w[4'd15 - c];
    endfunction

    assign pixel = rom_bit(select, row, col);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every sclk rising edge must carry the next expected bit.
    initial begin
        logic sclk_prev;
        logic b;
        sclk_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && sclk === 1'b1 && sclk_prev === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("sclk_unexpected", 32'd1, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    check("sdata", {31'd0, sdata}, {31'd0, b});
                end
            end
            sclk_prev = sclk;
        end
    end

    task automatic run_row(input int r, input logic [1:0] s, input bit frame_end, input logic [1:0] sel_after);
        int n;
        logic [15:0] exp_en;
        exp_en = 16'd1 << r;
        check("row_at_start", row, r);
        for (int c = 0; c < 16; c++) exp_q.push_back(rom_bit(s, 4'(r), 4'(c)));
        n = 0;
        while (latch !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("latch_seen", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        if (first_row) begin
            check("enable_to_latch_edges", n, 65);
            first_row = 1'b0;
        end
        if (have_latch) check("latch_period", cyc - last_latch, ROW_PERIOD);
        last_latch = cyc;
        have_latch = 1'b1;
        check("row_en_blank_in_shift", row_en, 0);
        check("sclk_low_at_latch", sclk, 0);
        check("bits_consumed", exp_q.size(), 0);
        @(negedge clk);
        check("latch_width", latch, 0);
        n = 0;
        while (row_en === exp_en && n < ROW_HOLD + 10) begin
            n++;
            @(negedge clk);
        end
        check("row_hold_len", n, ROW_HOLD);
        check("row_en_off", row_en, 0);
        check("frame_done", frame_done, frame_end);
        check("row_next", row, (r + 1) % 16);
        check("select", select, sel_after);
        if (frame_end) begin
            if (last_fd >= 0) check("frame_period", cyc - last_fd, FRAME_PERIOD);
            last_fd = cyc;
            @(negedge clk);
            check("frame_done_width", frame_done, 0);
        end
    endtask

    task automatic run_frame(input logic [1:0] s, input logic [1:0] sel_after);
        for (int r = 0; r < 16; r++) run_row(r, s, r == 15, (r == 15) ? sel_after : s);
    endtask

    task automatic do_abort(input logic [1:0] s);
        int n;
        for (int r = 0; r < 5; r++) run_row(r, s, 1'b0, s);
        for (int c = 0; c < 16; c++) exp_q.push_back(rom_bit(s, 4'd5, 4'(c)));
        n = 0;
        while (!(row === 4'd5 && col === 4'd7) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_point_reached", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        exp_q.delete();
        check("abort_row", row, 0);
        check("abort_col", col, 0);
        check("abort_row_en", row_en, 0);
        check("abort_sclk_latch", {sclk, latch, sdata, frame_done}, 0);
        check("abort_select_kept", select, s);
        repeat (3) @(negedge clk);
        check("abort_idle_row_en", row_en, 0);
        first_row  = 1'b1;
        have_latch = 1'b0;
        last_fd    = -1;
        enable     = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{sel: 2'd1, sel_after: 2'd1, abort_before: 1'b0};
        tbl[1] = '{sel: 2'd1, sel_after: 2'd2, abort_before: 1'b0};
        tbl[2] = '{sel: 2'd2, sel_after: 2'd2, abort_before: 1'b0};
        tbl[3] = '{sel: 2'd2, sel_after: 2'd1, abort_before: 1'b1};
        tbl[4] = '{sel: 2'd1, sel_after: 2'd1, abort_before: 1'b0};
        tbl[5] = '{sel: 2'd1, sel_after: 2'd2, abort_before: 1'b0};

        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_row", row, 0);
        check("rst_col", col, 0);
        check("rst_select", select, 1);
        check("rst_row_en", row_en, 0);
        check("rst_sclk", sclk, 0);
        check("rst_latch", latch, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_sdata", sdata, 0);

        enable = 1'b0;
        rst_n  = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_disabled", {row_en, sclk, latch}, 0);

        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].abort_before) do_abort(tbl[i].sel);
            run_frame(tbl[i].sel, tbl[i].sel_after);
        end

        // Asynchronous reset while a row is lit with glyph 2 selected.
        for (int c = 0; c < 16; c++) exp_q.push_back(rom_bit(2'd2, 4'd0, 4'(c)));
        begin
            int n;
            n = 0;
            while (row_en === 16'h0000 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("display_reached", row_en, 16'h0001);
        end
        check("select_before_reset", select, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_row_en", row_en, 0);
        check("async_rst_select", select, 1);
        check("async_rst_row", row, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Scan controller for the 16x16 LED dot-matrix panel. It drives the glyph ROM's `row`, `col` and `select` inputs and reads back its one-bit `word` pixel. Each row's 16 pixels are shifted serially into the panel's column shift register, then latched, then that row is lit for a fixed hold time. Every `FRAMES_PER_GLYPH` complete frames it alternates the displayed glyph.

## Interface
Parameters:
- `CLK_DIV`, 4: clk cycles per shifted bit; must be even and ≥4.
- `ROW_HOLD`, 1000: clk cycles each row stays lit; must be ≥1.
- `FRAMES_PER_GLYPH`, 60: full frames shown before `select` toggles; must be ≥1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scanning allowed when high.
- `pixel`  in  1  glyph ROM `word` output; combinational in `row`/`col`/`select`.
- `row`  out  4  row index presented to the glyph ROM.
- `col`  out  4  column index presented to the glyph ROM.
- `select`  out  2  glyph select to the ROM; only values 1 and 2 are used.
- `sclk`  out  1  column shift clock to the panel.
- `sdata`  out  1  column serial data to the panel.
- `latch`  out  1  column register latch strobe, one cycle wide.
- `row_en`  out  16  one-hot row drive, bit n = row n, active-high.
- `frame_done`  out  1  one-cycle pulse after row 15's hold completes.

All outputs are registered. Clock is `clk`; reset is `rst_n`: asynchronous assert, active-low.

## Operation
- States: IDLE, SHIFT, LATCH, DISPLAY.
- Reset values: state IDLE, `row`=0, `col`=0, `select`=1, `sclk`=0, `sdata`=0, `latch`=0, `row_en`=0, `frame_done`=0.
- Internal counters reset to 0: bit phase `p` (0..CLK_DIV-1), hold counter, frame counter.
- IDLE:
  - All panel outputs stay at reset values.
  - Moves to SHIFT on the first cycle `enable`=1 is sampled.
- SHIFT:
  - `row_en`=0, so the panel is blank while shifting.
  - Each of 16 bits takes CLK_DIV cycles, col 0 first.
  - At p=0, `sdata` ← `pixel`, giving the ROM value for the current `row`/`col`/`select`.
  - `sclk` is registered high for p in [CLK_DIV/2, CLK_DIV-1] and low otherwise.
  - At p=CLK_DIV-1, `col` increments; 15 wraps to 0.
  - After bit 15, goes to LATCH.
- LATCH:
  - `latch`=1 for exactly one cycle; `sclk`=0; `sdata` holds.
  - Next state is DISPLAY.
- DISPLAY:
  - `row_en`=1<<`row` for exactly ROW_HOLD cycles.
  - On the last hold cycle, `row` increments (15 wraps to 0) and the state returns to SHIFT.
- Frame end, on the row 15→0 wrap:
  - `frame_done` pulses on that cycle; the frame counter increments.
  - When the counter reaches FRAMES_PER_GLYPH, it clears and `select` toggles 1↔2 on the same cycle.
- Disable:
  - `enable` low in any state forces IDLE on the next edge.
  - `row`, `col`, `p`, hold counter, `sclk`, `sdata`, `latch` and `row_en` return to reset values.
  - `select` and the frame counter are kept.
  - No `frame_done` is emitted on abort.
- Reset mid-operation: all outputs go immediately (asynchronously) to reset values, including `select`=1.

## Timing
- Enable to first `sdata`: `sdata` for col 0 is valid 2 cycles after the edge that samples `enable`=1 (1 cycle to SHIFT, then the p=0 capture).
- Per bit: `sdata` is stable from p=1 through the end of the bit. The `sclk` rising edge, seen at the output at p=CLK_DIV/2, gives ≥1 cycle setup and ≥CLK_DIV/2 cycles hold.
- Row period: 16·CLK_DIV + 1 + ROW_HOLD cycles. With defaults this is 64+1+1000 = 1065.
- Frame period: 16 × row period = 17040 cycles with defaults.
- `row_en` transitions:
  - Goes nonzero on the cycle after `latch`.
  - Goes to 0 on the cycle the next SHIFT begins.
- Simultaneous events: `frame_done`, the `select` toggle and the `row` wrap all occur on the same edge. The next SHIFT reads the ROM with the new `select`.

## Test plan
- Reset: hold `rst_n`=0 with `enable`=1 → `row`=0, `col`=0, `select`=1, `row_en`=0x0000, `sclk`=`latch`=`frame_done`=0.
- Row shift: connect the glyph ROM, `enable`=1, `select`=1, advance to row 2 → the 16 `sdata` values sampled at `sclk` rising edges are 0000111111110000, col 0 first.
- Row timing: `latch` pulses 65 cycles after SHIFT entry (CLK_DIV=4). Then `row_en`=0x0004 for exactly 1000 cycles, then 0x0000.
- Glyph toggle: FRAMES_PER_GLYPH=2, ROW_HOLD=4 → `frame_done` every 16·(64+1+4)=1104 cycles. `select` goes 1→2 at the 2nd pulse and back to 1 at the 4th. Row 1 shifts 1110000000000111 while `select`=2.
- Abort: drop `enable` at bit 7 of row 5 → next cycle IDLE, `row`=0, `col`=0, `row_en`=0, `select` unchanged. Re-enable → shifting restarts at row 0, col 0.
- Reset mid-DISPLAY: assert `rst_n`=0 mid-hold → `row_en` goes to 0x0000 and `select` goes to 1 without waiting for a clock edge.
